// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that sequences operations through a shared
// 8-bit ALU with registered latency and returns results tagged with the requester ID.
module alu_arbiter #(
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       REQ0_VALID,
   output logic       REQ0_READY,
   input  logic [7:0] REQ0_A,
   input  logic [7:0] REQ0_B,
   input  logic [3:0] REQ0_OP,
   input  logic       REQ1_VALID,
   output logic       REQ1_READY,
   input  logic [7:0] REQ1_A,
   input  logic [7:0] REQ1_B,
   input  logic [3:0] REQ1_OP,
   output logic [7:0] ALU_A,
   output logic [7:0] ALU_B,
   output logic [3:0] ALU_OP,
   input  logic [7:0] ALU_RESULT,
   output logic       RSP_VALID,
   input  logic       RSP_READY,
   output logic       RSP_ID,
   output logic [7:0] RSP_DATA,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

   state_t     state;
   state_t     state_nxt;
   logic       last_gnt;
   logic [3:0] lat_cnt;
   logic       gnt_id;
   logic       accept;

   // On a tie the requester that did not win last time is granted.
   assign gnt_id     = REQ1_VALID && (!REQ0_VALID || !last_gnt);
   assign REQ0_READY = RESETN && (state == IDLE) && REQ0_VALID && !gnt_id;
   assign REQ1_READY = RESETN && (state == IDLE) && gnt_id;
   assign accept     = REQ0_READY || REQ1_READY;

   assign RSP_VALID  = (state == RESP);
   assign BUSY       = (state != IDLE);

   // NOTE: next_state is assigned its default before the case so no path infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)           state_nxt = EXEC;
         EXEC:    if (lat_cnt == 4'd0)  state_nxt = RESP;
         RESP:    if (RSP_READY)        state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: the datapath registers are reset because their reset values are visible on the outputs.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ALU_A    <= 8'd0;
         ALU_B    <= 8'd0;
         ALU_OP   <= 4'd0;
         RSP_ID   <= 1'b0;
         RSP_DATA <= 8'd0;
         last_gnt <= 1'b1;
         lat_cnt  <= 4'd0;
      end else if (accept) begin
         ALU_A    <= gnt_id ? REQ1_A  : REQ0_A;
         ALU_B    <= gnt_id ? REQ1_B  : REQ0_B;
         ALU_OP   <= gnt_id ? REQ1_OP : REQ0_OP;
         RSP_ID   <= gnt_id;
         last_gnt <= gnt_id;
         lat_cnt  <= LAT_LOAD;
      end else if (state == EXEC) begin
         // Count down the ALU pipeline; the result is taken when the count reaches zero.
         if (lat_cnt == 4'd0) RSP_DATA <= ALU_RESULT;
         else                 lat_cnt  <= lat_cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// checked each cycle against a timing-rule reference model.
module tb_alu_arbiter;

   localparam int L1 = 1;
   localparam int L3 = 3;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] req0_op, req1_op;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [3:0] alu_op;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_data;

   logic       d3_valid, d3_ready, d3_r1_ready;
   logic [7:0] d3_a, d3_b, d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_data;
   logic [3:0] d3_op, d3_alu_op;
   logic       d3_rsp_valid, d3_rsp_ready, d3_rsp_id, d3_busy;

   alu_arbiter #(.ALU_LATENCY(L1)) dut (
      .CLK(clk), .RESETN(resetn),
      .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready),
      .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_OP(req0_op),
      .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready),
      .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_OP(req1_op),
      .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .ALU_RESULT(alu_result),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
      .RSP_DATA(rsp_data), .BUSY(busy)
   );

   alu_arbiter #(.ALU_LATENCY(L3)) dut3 (
      .CLK(clk), .RESETN(resetn),
      .REQ0_VALID(d3_valid), .REQ0_READY(d3_ready),
      .REQ0_A(d3_a), .REQ0_B(d3_b), .REQ0_OP(d3_op),
      .REQ1_VALID(1'b0), .REQ1_READY(d3_r1_ready),
      .REQ1_A(8'd0), .REQ1_B(8'd0), .REQ1_OP(4'd0),
      .ALU_A(d3_alu_a), .ALU_B(d3_alu_b), .ALU_OP(d3_alu_op), .ALU_RESULT(d3_alu_result),
      .RSP_VALID(d3_rsp_valid), .RSP_READY(d3_rsp_ready), .RSP_ID(d3_rsp_id),
      .RSP_DATA(d3_rsp_data), .BUSY(d3_busy)
   );

   // Environment ALU: 16 opcodes, result delayed by ALU_LATENCY register stages.
   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a ^ b;
         4'h3: return a | b;
         4'h4: return a << 1;
         4'h5: return a >> 1;
         4'h6: return ~a;
         4'h7: return a + 8'd1;
         4'h8: return a - 8'd1;
         4'h9: return {7'd0, a == b};
         4'hA: return {7'd0, a < b};
         4'hB: return b;
         4'hC: return a & b;
         4'hD: return ~(a & b);
         4'hE: return a;
         default: return {a[3:0], a[7:4]};
      endcase
   endfunction

   always @(posedge clk) alu_result <= alu_f(alu_op, alu_a, alu_b);

   logic [7:0] p3 [3];
   always @(posedge clk) begin
      p3[0] <= alu_f(d3_alu_op, d3_alu_a, d3_alu_b);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign d3_alu_result = p3[2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: an accepted op occupies the arbiter for a fixed number of
   // cycles, then a response is offered until the consumer takes it.
   logic       m_busy, m_last, m_id;
   int         m_age;
   logic [7:0] m_a, m_b, m_rsp_data;
   logic [3:0] m_op;
   logic       acc0, acc1;
   logic [8:0] obs_q [$];

   task automatic model_reset();
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
      m_a = 8'd0; m_b = 8'd0; m_op = 4'd0; m_rsp_data = 8'd0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".req0_ready"}, req0_ready, 0);
      check({tag, ".req1_ready"}, req1_ready, 0);
      check({tag, ".rsp_valid"},  rsp_valid,  0);
      check({tag, ".busy"},       busy,       0);
      check({tag, ".alu_a"},      alu_a,      0);
      check({tag, ".alu_b"},      alu_b,      0);
      check({tag, ".alu_op"},     alu_op,     0);
      check({tag, ".rsp_id"},     rsp_id,     0);
      check({tag, ".rsp_data"},   rsp_data,   0);
   endtask

   // Called at a falling edge with inputs already driven; checks, then advances one cycle.
   task automatic cycle(input string tag);
      logic e_r0, e_r1, e_rv;
      #1;
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!m_busy) begin
         e_r0 = req0_valid && (!req1_valid || m_last);
         e_r1 = req1_valid && (!req0_valid || !m_last);
         e_rv = 1'b0;
      end else begin
         e_r0 = 1'b0;
         e_r1 = 1'b0;
         e_rv = (m_age >= L1 + 2);
      end
      check({tag, ".req0_ready"}, req0_ready, e_r0);
      check({tag, ".req1_ready"}, req1_ready, e_r1);
      check({tag, ".both_ready"}, req0_ready & req1_ready, 0);
      check({tag, ".busy"},       busy,       m_busy);
      check({tag, ".rsp_valid"},  rsp_valid,  e_rv);
      check({tag, ".alu_a"},      alu_a,      m_a);
      check({tag, ".alu_b"},      alu_b,      m_b);
      check({tag, ".alu_op"},     alu_op,     m_op);
      check({tag, ".rsp_id"},     rsp_id,     m_id);
      check({tag, ".rsp_data"},   rsp_data,   m_rsp_data);
      if (rsp_valid && rsp_ready) obs_q.push_back({rsp_id, rsp_data});
      if (!m_busy) begin
         if (e_r0 || e_r1) begin
            m_id   = e_r1;
            m_last = e_r1;
            m_a    = e_r1 ? req1_a  : req0_a;
            m_b    = e_r1 ? req1_b  : req0_b;
            m_op   = e_r1 ? req1_op : req0_op;
            m_busy = 1'b1;
            m_age  = 1;
            acc0   = e_r0;
            acc1   = e_r1;
         end
      end else if (e_rv && rsp_ready) begin
         m_busy = 1'b0;
      end else begin
         m_age++;
         if (m_age == L1 + 2) m_rsp_data = alu_f(m_op, m_a, m_b);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h01; req0_op = 4'h1;
      req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h10; req1_op = 4'h2;
      d3_valid = 1'b0; d3_a = 8'd0; d3_b = 8'd0; d3_op = 4'd0; d3_rsp_ready = 1'b1;
      model_reset();

      // Reset values, with both requesters already valid
      repeat (2) @(negedge clk);
      #1 check_reset("reset");
      @(negedge clk);
      resetn = 1'b1;

      // Contention and fairness: six ops with both VALID held
      for (int n = 0; n < 60 && obs_q.size() < 6; n++) cycle("contend");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("contend.count", 16'(obs_q.size()), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < obs_q.size()) begin
            check("contend.id",   obs_q[i][8],   (i % 2 == 1));
            check("contend.data", obs_q[i][7:0], (i % 2 == 1) ? 8'h00 : 8'hFF);
         end
      end
      repeat (2) cycle("idle");
      obs_q.delete();

      // Single op, default latency
      req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'h0;
      cycle("single.t0");
      req0_valid = 1'b0;
      repeat (4) cycle("single");
      check("single.count", 16'(obs_q.size()), 1);
      if (obs_q.size() > 0) check("single.rsp", obs_q[0], {1'b0, 8'h08});
      obs_q.delete();

      // Back-pressure: response held five cycles while requester 0 waits
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h3C; req1_op = 4'h9;
      cycle("bp.t0");
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 4'h3;
      repeat (7) cycle("bp.hold");
      check("bp.hold_data", rsp_data, 8'h01);
      check("bp.hold_id",   rsp_id,   1);
      rsp_ready = 1'b1;
      cycle("bp.release");
      cycle("bp.next_grant");
      check("bp.req0_taken", acc0, 1);
      req0_valid = 1'b0;
      repeat (4) cycle("bp.drain");
      check("bp.count", 16'(obs_q.size()), 2);
      if (obs_q.size() > 1) begin
         check("bp.rsp0", obs_q[0], {1'b1, 8'h01});
         check("bp.rsp1", obs_q[1], {1'b0, 8'h33});
      end
      obs_q.delete();

      // Reset in the middle of EXEC: op dropped, tie goes to requester 0 again
      req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h02; req0_op = 4'h0;
      cycle("rst.t0");
      req0_valid = 1'b0;
      cycle("rst.exec");
      #2 resetn = 1'b0;
      req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h01; req0_op = 4'h1;
      req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; req1_op = 4'h3;
      #1 check_reset("rst.mid");
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      cycle("rst.tie");
      check("rst.tie_gnt0", acc0, 1);
      req0_valid = 1'b0;
      for (int n = 0; n < 20 && obs_q.size() < 2; n++) begin
         cycle("rst.after");
         if (acc1) req1_valid = 1'b0;
      end
      check("rst.count", 16'(obs_q.size()), 2);
      if (obs_q.size() > 1) begin
         check("rst.rsp0", obs_q[0], {1'b0, 8'h06});
         check("rst.rsp1", obs_q[1], {1'b1, 8'hFF});
      end
      req1_valid = 1'b0;
      repeat (2) cycle("rst.idle");
      obs_q.delete();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if (!req0_valid && $urandom_range(2) == 0) begin
            req0_valid = 1'b1;
            req0_a = 8'($urandom_range(255)); req0_b = 8'($urandom_range(255));
            req0_op = 4'($urandom_range(15));
         end else if (req0_valid && $urandom_range(15) == 0) begin
            req0_valid = 1'b0;
         end
         if (!req1_valid && $urandom_range(2) == 0) begin
            req1_valid = 1'b1;
            req1_a = 8'($urandom_range(255)); req1_b = 8'($urandom_range(255));
            req1_op = 4'($urandom_range(15));
         end else if (req1_valid && $urandom_range(15) == 0) begin
            req1_valid = 1'b0;
         end
         rsp_ready = ($urandom_range(3) != 0);
         cycle("rand");
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) cycle("drain");
      check("drain.busy", busy, 0);

      // Latency 3 instance: response five cycles after accept
      d3_valid = 1'b1; d3_a = 8'hF0; d3_b = 8'h3C; d3_op = 4'hC;
      #1 check("l3.ready", d3_ready, 1);
      check("l3.req1_ready", d3_r1_ready, 0);
      @(negedge clk);
      d3_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         #1;
         check("l3.rsp_valid", d3_rsp_valid, (k == L3 + 2));
         check("l3.busy",      d3_busy,      (k <= L3 + 2));
         check("l3.alu_a",     d3_alu_a,     8'hF0);
         check("l3.alu_b",     d3_alu_b,     8'h3C);
         check("l3.alu_op",    d3_alu_op,    4'hC);
         if (k == L3 + 2) begin
            check("l3.rsp_data", d3_rsp_data, 8'h30);
            check("l3.rsp_id",   d3_rsp_id,   0);
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
